// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Sequential hazard controller for the 16-bit pipelined core.
//            Keeps a small scoreboard of in-flight register writes (EX, MEM,
//            WB), produces a registered forward select per source operand for
//            the instruction now in EX, and raises a stall for load-use
//            hazards and while a multi-cycle mult/div occupies EX.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   id_valid    in   ID holds a live instruction
//   id_rs       in   NUM_SRC*REG_W source addresses, operand i at [i*REG_W +: REG_W]
//   id_rs_used  in   NUM_SRC operand-read flags (0 for immediates)
//   id_rd       in   REG_W destination register
//   id_we       in   instruction writes id_rd
//   id_load     in   instruction is a load
//   id_mdu      in   instruction is mult/div
//   flush       in   kill the ID instruction (branch redirect)
//   fwd_sel     out  NUM_SRC*2 registered forward selects
//                      0 = register file, 1 = EX/MEM, 2 = MEM/WB,
//                      3 = WB bypass latch (WB_BYPASS_EN only)
//   stall       out  freeze PC and IF/ID this cycle
//   mdu_busy    out  MDU instruction still iterating in EX
// ----------------------------------------------------------------------------
// Build option
//   WB_BYPASS_EN  defined  : a WB-stage match selects 3 (WB data latch), so
//                            the register file may be write-after-read.
//                 undefined: a WB-stage match selects 0; the register file
//                            must be write-first. Select 3 is never produced.
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 2,
  parameter int MDU_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_we,
  input  logic                     id_load,
  input  logic                     id_mdu,
  input  logic                     flush,
  output logic [NUM_SRC*2-1:0]     fwd_sel,
  output logic                     stall,
  output logic                     mdu_busy
);

  // MDU countdown width: holds MDU_LAT-1, at least one bit.
  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] c_MDU_RELOAD = CNT_W'(MDU_LAT - 1);

  localparam logic [1:0] c_SEL_RF  = 2'd0;
  localparam logic [1:0] c_SEL_EX  = 2'd1;
  localparam logic [1:0] c_SEL_MEM = 2'd2;
`ifdef WB_BYPASS_EN
  localparam logic [1:0] c_SEL_WB  = 2'd3;
`else
  // Write-first register file already returns the WB value.
  localparam logic [1:0] c_SEL_WB  = 2'd0;
`endif

  // Pipeline advance mode for the current cycle.
  localparam logic [1:0] c_MODE_RUN = 2'd0;  // normal advance
  localparam logic [1:0] c_MODE_LDU = 2'd1;  // load-use bubble insertion
  localparam logic [1:0] c_MODE_MDU = 2'd2;  // MDU holding EX

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic                     r_ex_vld;
  logic [REG_W-1:0]         r_ex_rd;
  logic                     r_ex_load;
  logic                     r_mem_vld;
  logic [REG_W-1:0]         r_mem_rd;
  logic                     r_wb_vld;
  logic [REG_W-1:0]         r_wb_rd;
  logic [CNT_W-1:0]         r_mdu_cnt;
  logic [NUM_SRC*2-1:0]     r_fwd_sel;

  // --------------------------------------------------------------------------
  // ID-side hazard detection
  // --------------------------------------------------------------------------
  logic                     w_id_live;
  logic [NUM_SRC-1:0]       w_hit_ex;
  logic [NUM_SRC-1:0]       w_hit_mem;
  logic [NUM_SRC-1:0]       w_hit_wb;
  logic [NUM_SRC*2-1:0]     w_sel;
  logic                     w_load_use;
  logic                     w_mdu_busy;
  logic [1:0]               w_mode;

  // A flushed instruction is dead: it neither stalls nor enters EX.
  assign w_id_live = id_valid & ~flush;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_W-1:0] w_rs;
      assign w_rs = id_rs[gi*REG_W +: REG_W];

      // Unused operands never match, which forces their select to 0.
      assign w_hit_ex[gi]  = id_rs_used[gi] & r_ex_vld  & (w_rs == r_ex_rd);
      assign w_hit_mem[gi] = id_rs_used[gi] & r_mem_vld & (w_rs == r_mem_rd);
      assign w_hit_wb[gi]  = id_rs_used[gi] & r_wb_vld  & (w_rs == r_wb_rd);

      // Youngest producer wins.
      assign w_sel[gi*2 +: 2] = w_hit_ex[gi]  ? c_SEL_EX  :
                                w_hit_mem[gi] ? c_SEL_MEM :
                                w_hit_wb[gi]  ? c_SEL_WB  :
                                                c_SEL_RF;
    end
  endgenerate

  // Load data is only available from MEM/WB, so a consumer directly behind
  // a load must wait one cycle.
  assign w_load_use = w_id_live & r_ex_vld & r_ex_load & (|w_hit_ex);
  assign w_mdu_busy = (r_mdu_cnt != '0);

  // MDU occupancy outranks load-use: EX is frozen, nothing can move behind it.
  always_comb begin
    w_mode = c_MODE_RUN;
    if (w_mdu_busy) begin
      w_mode = c_MODE_MDU;
    end else if (w_load_use) begin
      w_mode = c_MODE_LDU;
    end
  end

  // --------------------------------------------------------------------------
  // Stage advance
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_vld  <= 1'b0;
      r_ex_rd   <= '0;
      r_ex_load <= 1'b0;
      r_mem_vld <= 1'b0;
      r_mem_rd  <= '0;
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= '0;
      r_mdu_cnt <= '0;
      r_fwd_sel <= '0;
    end else begin
      // WB always takes whatever MEM held.
      r_wb_vld <= r_mem_vld;
      r_wb_rd  <= r_mem_rd;

      case (w_mode)
        c_MODE_MDU: begin
          // EX and fwd_sel hold for the iterating instruction; a bubble
          // drains into MEM behind it.
          r_mem_vld <= 1'b0;
          r_mem_rd  <= '0;
          r_mdu_cnt <= r_mdu_cnt - 1'b1;
        end

        c_MODE_LDU: begin
          // The load moves on to MEM; EX becomes a bubble while ID is held.
          r_mem_vld <= r_ex_vld;
          r_mem_rd  <= r_ex_rd;
          r_ex_vld  <= 1'b0;
          r_ex_rd   <= '0;
          r_ex_load <= 1'b0;
          r_fwd_sel <= '0;
        end

        default: begin
          r_mem_vld <= r_ex_vld;
          r_mem_rd  <= r_ex_rd;
          if (w_id_live) begin
            r_ex_vld  <= id_we;
            r_ex_rd   <= id_rd;
            r_ex_load <= id_load & id_we;
            r_fwd_sel <= w_sel;
            r_mdu_cnt <= id_mdu ? c_MDU_RELOAD : '0;
          end else begin
            r_ex_vld  <= 1'b0;
            r_ex_rd   <= '0;
            r_ex_load <= 1'b0;
            r_fwd_sel <= '0;
            r_mdu_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign fwd_sel  = r_fwd_sel;
  assign stall    = w_load_use | w_mdu_busy;
  assign mdu_busy = w_mdu_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
//            randomized traffic against a behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_W   = 4;
  localparam int NUM_SRC = 2;
  localparam int MDU_LAT = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_rs;
  logic [NUM_SRC-1:0]       id_rs_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_we;
  logic                     id_load;
  logic                     id_mdu;
  logic                     flush;
  logic [NUM_SRC*2-1:0]     fwd_sel;
  logic                     stall;
  logic                     mdu_busy;

  pipe_hazard_ctrl #(
    .REG_W   (REG_W),
    .NUM_SRC (NUM_SRC),
    .MDU_LAT (MDU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_load    (id_load),
    .id_mdu     (id_mdu),
    .flush      (flush),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .mdu_busy   (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: slot 0 = EX, 1 = MEM, 2 = WB; distance to a producer
  // decides the select.
  // --------------------------------------------------------------------------
  typedef struct {
    bit vld;
    int rd;
    bit load;
  } slot_t;

  slot_t pipe[3];
  int    mdu_left;
  int    exp_fwd[NUM_SRC];
  bit    exp_stall;
  bit    obs_stall;

  function automatic int model_sel(input int rs);
    for (int d = 0; d < 3; d++) begin
      if (pipe[d].vld && pipe[d].rd == rs) begin
        if (d == 2) return BYPASS ? 3 : 0;
        return d + 1;
      end
    end
    return 0;
  endfunction

  function automatic logic [NUM_SRC*2-1:0] model_fwd();
    logic [NUM_SRC*2-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) v[i*2 +: 2] = 2'(exp_fwd[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      pipe[d].vld = 0; pipe[d].rd = 0; pipe[d].load = 0;
    end
    mdu_left = 0;
    for (int i = 0; i < NUM_SRC; i++) exp_fwd[i] = 0;
  endtask

  // Drive one ID cycle, sample stall before the edge, advance the model,
  // then return 1 time unit after the clock edge.
  task automatic step(input bit v, input int rs0, input bit u0, input int rs1,
                      input bit u1, input int rd, input bit we, input bit ld,
                      input bit mdu, input bit fl);
    bit live;
    bit ldu;
    int nsel[NUM_SRC];
    id_valid   = v;
    id_rs      = {REG_W'(rs1), REG_W'(rs0)};
    id_rs_used = {u1, u0};
    id_rd      = REG_W'(rd);
    id_we      = we;
    id_load    = ld;
    id_mdu     = mdu;
    flush      = fl;
    #1;
    obs_stall = stall;
    live = v && !fl;
    ldu  = live && pipe[0].vld && pipe[0].load &&
           ((u0 && rs0 == pipe[0].rd) || (u1 && rs1 == pipe[0].rd));
    exp_stall = (mdu_left > 0) || ldu;
    if (mdu_left > 0) begin
      pipe[2] = pipe[1];
      pipe[1].vld = 0; pipe[1].rd = 0; pipe[1].load = 0;
      mdu_left--;
    end else if (ldu) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].vld = 0; pipe[0].rd = 0; pipe[0].load = 0;
      for (int i = 0; i < NUM_SRC; i++) exp_fwd[i] = 0;
    end else begin
      nsel[0] = (live && u0) ? model_sel(rs0) : 0;
      nsel[1] = (live && u1) ? model_sel(rs1) : 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0].vld  = live && we;
      pipe[0].rd   = rd;
      pipe[0].load = live && we && ld;
      for (int i = 0; i < NUM_SRC; i++) exp_fwd[i] = nsel[i];
      mdu_left = (live && mdu) ? MDU_LAT - 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_we = 0; id_load = 0; id_mdu = 0; flush = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b expected 0000", fwd_sel);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    checks++;
    if (mdu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mdu_busy: got %b expected 0", mdu_busy);
    end
  endtask

  task automatic test_back_to_back();
    bit any_stall;
    do_reset();
    step(1, 4, 1, 0, 1, 3, 1, 0, 0, 0);  // add r3 <- r4, r0
    any_stall = obs_stall;
    step(1, 3, 1, 1, 1, 5, 1, 0, 0, 0);  // add r5 <- r3, r1
    any_stall |= obs_stall;
    checks++;
    if (fwd_sel !== 4'b0001) begin
      errors++; $display("FAIL b2b_fwd: got %b expected 0001", fwd_sel);
    end
    checks++;
    if (any_stall !== 1'b0) begin
      errors++; $display("FAIL b2b_stall: got %b expected 0", any_stall);
    end
  endtask

  task automatic test_distance2();
    do_reset();
    step(1, 4, 1, 5, 1, 3, 1, 0, 0, 0);  // r3 producer
    step(1, 8, 1, 9, 1, 7, 1, 0, 0, 0);  // independent
    step(1, 3, 1, 10, 1, 11, 1, 0, 0, 0); // consumer of r3 on operand 0
    checks++;
    if (fwd_sel !== 4'b0010) begin
      errors++; $display("FAIL dist2_fwd: got %b expected 0010", fwd_sel);
    end
  endtask

  task automatic test_distance3();
    logic [3:0] want;
    want = BYPASS ? 4'b1100 : 4'b0000;
    do_reset();
    step(1, 4, 1, 5, 1, 3, 1, 0, 0, 0);   // r3 producer
    step(1, 8, 1, 9, 1, 7, 1, 0, 0, 0);   // independent
    step(1, 9, 1, 8, 1, 12, 1, 0, 0, 0);  // independent
    step(1, 10, 1, 3, 1, 11, 1, 0, 0, 0); // consumer of r3 on operand 1
    checks++;
    if (fwd_sel !== want) begin
      errors++; $display("FAIL dist3_fwd: got %b expected %b", fwd_sel, want);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step(1, 5, 1, 0, 0, 2, 1, 1, 0, 0);  // load r2
    step(1, 2, 1, 2, 1, 6, 1, 0, 0, 0);  // add r6 <- r2, r2 : stalls
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++; $display("FAIL ldu_stall: got %b expected 1", obs_stall);
    end
    checks++;
    if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL ldu_bubble_fwd: got %b expected 0000", fwd_sel);
    end
    step(1, 2, 1, 2, 1, 6, 1, 0, 0, 0);  // re-evaluated, proceeds
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++; $display("FAIL ldu_stall_once: got %b expected 0", obs_stall);
    end
    checks++;
    if (fwd_sel !== 4'b1010) begin
      errors++; $display("FAIL ldu_fwd: got %b expected 1010", fwd_sel);
    end
  endtask

  task automatic test_mdu();
    int stalls;
    bit done;
    do_reset();
    step(1, 1, 1, 2, 1, 0, 1, 0, 1, 0);  // mul r0 <- r1, r2
    checks++;
    if (mdu_busy !== 1'b1) begin
      errors++; $display("FAIL mdu_busy_start: got %b expected 1", mdu_busy);
    end
    stalls = 0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      step(1, 0, 1, 5, 1, 7, 1, 0, 0, 0);  // add r7 <- r0, r5
      if (obs_stall) stalls++;
      else done = 1;
    end
    checks++;
    if (!done || stalls != MDU_LAT - 1) begin
      errors++; $display("FAIL mdu_stall_len: got %0d done=%0d expected %0d", stalls, done, MDU_LAT - 1);
    end
    checks++;
    if (fwd_sel !== 4'b0001) begin
      errors++; $display("FAIL mdu_consumer_fwd: got %b expected 0001", fwd_sel);
    end
    checks++;
    if (mdu_busy !== 1'b0) begin
      errors++; $display("FAIL mdu_busy_end: got %b expected 0", mdu_busy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    // Flushed MDU op: no counter load, EX stays a bubble.
    step(1, 1, 1, 2, 1, 4, 1, 0, 1, 1);
    checks++;
    if (mdu_busy !== 1'b0) begin
      errors++; $display("FAIL flush_mdu_busy: got %b expected 0", mdu_busy);
    end
    step(1, 4, 1, 0, 0, 9, 1, 0, 0, 0);
    checks++;
    if (fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL flush_bubble_fwd: got %b expected 0000", fwd_sel);
    end
    // Flush beats load-use.
    step(1, 5, 1, 0, 0, 2, 1, 1, 0, 0);
    step(1, 2, 1, 2, 1, 6, 1, 0, 0, 1);
    checks++;
    if (obs_stall !== 1'b0) begin
      errors++; $display("FAIL flush_ldu_stall: got %b expected 0", obs_stall);
    end
    // Flush while MDU busy leaves the MDU op in EX.
    step(1, 1, 1, 2, 1, 6, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (obs_stall !== 1'b1) begin
      errors++; $display("FAIL flush_mdu_stall: got %b expected 1", obs_stall);
    end
    idle();
    idle();
    step(1, 6, 1, 0, 0, 8, 1, 0, 0, 0);
    checks++;
    if (fwd_sel !== 4'b0001) begin
      errors++; $display("FAIL flush_mdu_held_fwd: got %b expected 0001", fwd_sel);
    end
  endtask

  task automatic test_reset_mid_mdu();
    do_reset();
    step(1, 4, 1, 0, 0, 1, 1, 0, 0, 0);  // r1 producer
    step(1, 1, 1, 0, 0, 5, 1, 0, 1, 0);  // mul r5 <- r1 (select 1)
    idle();                              // mdu_cnt now 2
    checks++;
    if (mdu_busy !== 1'b1 || fwd_sel !== 4'b0001) begin
      errors++; $display("FAIL pre_rst_mdu: got busy=%b fwd=%b expected busy=1 fwd=0001", mdu_busy, fwd_sel);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (stall !== 1'b0 || mdu_busy !== 1'b0 || fwd_sel !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_mdu: got stall=%b busy=%b fwd=%b expected 0 0 0000", stall, mdu_busy, fwd_sel);
    end
  endtask

  task automatic test_random();
    bit v, u0, u1, we, ld, mdu, fl;
    int rs0, rs1, rd;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 7) != 0);
      rs0 = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3);
      u0  = ($urandom_range(0, 3) != 0);
      u1  = ($urandom_range(0, 3) != 0);
      rd  = $urandom_range(0, 3);
      we  = ($urandom_range(0, 5) != 0);
      ld  = ($urandom_range(0, 3) == 0);
      mdu = !ld && ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      step(v, rs0, u0, rs1, u1, rd, we, ld, mdu, fl);
      checks++;
      if (obs_stall !== exp_stall) begin
        errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", n, obs_stall, exp_stall);
      end
      checks++;
      if (fwd_sel !== model_fwd()) begin
        errors++; $display("FAIL rnd_fwd[%0d]: got %b expected %b", n, fwd_sel, model_fwd());
      end
      checks++;
      if (mdu_busy !== (mdu_left != 0)) begin
        errors++; $display("FAIL rnd_mdu_busy[%0d]: got %b expected %b", n, mdu_busy, (mdu_left != 0));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_distance3();
    test_load_use();
    test_mdu();
    test_flush();
    test_reset_mid_mdu();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
